// File: rtl/bus_arbiter_if.sv
// External memory bus shared by the fetch and load/store paths.
// The arbiter drives the request side; the memory answers with data and ack.
interface bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the memory bus: MEM stage has priority over IF.
// Returned data is held per requester until its pipeline stage advances.
module bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_if_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        stallreq_mem_o,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        M_BUSY,
        I_BUSY
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant_mem;
    logic        grant_if;
    logic        done_mem;
    logic        done_if;
    logic        mem_vld;
    logic        if_vld;
    logic [31:0] mem_hold;
    logic [31:0] if_hold;

    assign mem_rdata_o = mem_hold;
    assign if_data_o   = if_hold;

    assign stallreq_mem_o = !rst && !flush && mem_ce_i && !mem_vld;
    assign stallreq_if_o  = !rst && !flush && if_ce_i && !if_vld;

    // Next-state logic: grant in IDLE, finish a cycle on ack, flush aborts
    always_comb begin
        state_nxt = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        done_mem  = 1'b0;
        done_if   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush) begin
                    if (mem_ce_i && !mem_vld) begin
                        grant_mem = 1'b1;
                        state_nxt = M_BUSY;
                    end else if (if_ce_i && !if_vld) begin
                        grant_if  = 1'b1;
                        state_nxt = I_BUSY;
                    end
                end
            end
            M_BUSY: begin
                if (bus.ack && !flush) begin
                    done_mem  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            I_BUSY: begin
                if (bus.ack && !flush) begin
                    done_if   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered bus outputs, held stable while a cycle waits for ack
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= 32'h0;
            bus.sel   <= 4'h0;
            bus.wdata <= 32'h0;
        end else if (flush) begin
            bus.req <= 1'b0;
        end else if (grant_mem) begin
            bus.req   <= 1'b1;
            bus.we    <= mem_we_i;
            bus.addr  <= mem_addr_i;
            bus.sel   <= mem_sel_i;
            bus.wdata <= mem_wdata_i;
        end else if (grant_if) begin
            bus.req   <= 1'b1;
            bus.we    <= 1'b0;
            bus.addr  <= if_addr_i;
            bus.sel   <= 4'hF;
            bus.wdata <= 32'h0;
        end else if (done_mem || done_if) begin
            bus.req <= 1'b0;
        end
    end

    // Per-requester hold data; a new result wins over a same-edge release
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_vld  <= 1'b0;
            if_vld   <= 1'b0;
            mem_hold <= 32'h0;
            if_hold  <= 32'h0;
        end else if (flush) begin
            mem_vld <= 1'b0;
            if_vld  <= 1'b0;
        end else begin
            if (done_mem) begin
                mem_vld  <= 1'b1;
                mem_hold <= bus.rdata;
            end else if (!stall[4]) begin
                mem_vld <= 1'b0;
            end
            if (done_if) begin
                if_vld  <= 1'b1;
                if_hold <= bus.rdata;
            end else if (!stall[1]) begin
                if_vld <= 1'b0;
            end
        end
    end

endmodule
